// File: rtl/ws2812_pkg.sv
// Shared WS2812B definitions: receiver state encoding and 40 MHz line timing used by transmitter and receiver.
package ws2812_pkg;

  typedef enum logic [1:0] {WAIT_LOW, LOW, HIGH} rx_state_t;

  // Nominal symbol timing in 40 MHz clocks (25 ns each).
  localparam int T0H     = 16;
  localparam int T0L     = 34;
  localparam int T1H     = 32;
  localparam int T1L     = 18;
  localparam int T_RESET = 2000;

endpackage

// File: rtl/ws2812_pulse_meter.sv
// Synchronises din, flags its edges and measures the length of the current high/low run.
// cnt restarts at 1 on every edge (or while clr is held) and saturates at RESET_CYCLES.
module ws2812_pulse_meter #(
  parameter int RESET_CYCLES = 1600,
  parameter int CW           = $clog2(RESET_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          din,
  input  logic          clr,
  output logic          din_s,
  output logic          rise,
  output logic          fall,
  output logic [CW-1:0] cnt
);

  logic din_m;
  logic din_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_q <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_q <= din_s;
    end
  end

  assign rise = din_s & ~din_q;
  assign fall = ~din_s & din_q;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (clr || rise || fall)
      cnt <= CW'(1);
    else if (cnt != CW'(RESET_CYCLES))
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812B receiver: classifies high pulses into bits, assembles LSB-first 24-bit pixels, detects the latch gap.
// Define WS2812_FWD_EN to forward the stream on dout after the first pixel of each frame (LED chaining).
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int BIT_THRESH   = 24,
  parameter int MIN_HIGH     = 4,
  parameter int MAX_HIGH     = 48,
  parameter int RESET_CYCLES = 1600,
  parameter int PIX_W        = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic             frame_done,
  output logic             bit_error,
  output logic [PIX_W-1:0] pixel_count,
  output logic             dout
);

  localparam int CW = $clog2(RESET_CYCLES + 1);

  rx_state_t      state;
  logic [4:0]     bit_idx;
  logic [23:0]    shift_reg;
  logic           pix_pend;
  logic           active;
  logic           din_s;
  logic           rise;
  logic           fall;
  logic [CW-1:0]  cnt;

  ws2812_pulse_meter #(
    .RESET_CYCLES (RESET_CYCLES),
    .CW           (CW)
  ) u_meter (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .clr   (state == WAIT_LOW),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall),
    .cnt   (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_LOW;
      bit_idx     <= '0;
      shift_reg   <= '0;
      pix_pend    <= 1'b0;
      active      <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      pixel_count <= '0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      if (frame_done)
        pixel_count <= '0;
      // The 24th bit lands in shift_reg one cycle before it is published.
      if (pix_pend) begin
        pix_pend    <= 1'b0;
        pixel_data  <= shift_reg;
        pixel_valid <= 1'b1;
        if (pixel_count != {PIX_W{1'b1}})
          pixel_count <= pixel_count + PIX_W'(1);
      end
      case (state)
        WAIT_LOW: if (!din_s) state <= LOW;
        LOW: begin
          if (rise)
            state <= HIGH;
          else if (cnt == CW'(RESET_CYCLES) && active) begin
            frame_done <= 1'b1;
            active     <= 1'b0;
            bit_idx    <= '0;
            if (bit_idx != 5'd0)
              bit_error <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt > CW'(MAX_HIGH)) begin
            bit_error <= 1'b1;
            bit_idx   <= '0;
            state     <= WAIT_LOW;
          end else if (fall) begin
            state <= LOW;
            if (cnt < CW'(MIN_HIGH))
              bit_error <= 1'b1;
            else begin
              shift_reg[bit_idx] <= (cnt >= CW'(BIT_THRESH));
              active             <= 1'b1;
              if (bit_idx == 5'd23) begin
                bit_idx  <= '0;
                pix_pend <= 1'b1;
              end else
                bit_idx <= bit_idx + 5'd1;
            end
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

`ifdef WS2812_FWD_EN
  logic fwd_open;

  // This receiver consumes the first pixel of the frame; everything after it passes downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_open <= 1'b0;
      dout     <= 1'b0;
    end else begin
      if (frame_done)
        fwd_open <= 1'b0;
      else if (pix_pend)
        fwd_open <= 1'b1;
      dout <= din_s & fwd_open;
    end
  end
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomised scoreboard bench for ws2812_rx against a pulse-level reference model.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  localparam int BIT_THRESH = 24;
  localparam int MIN_HIGH   = 4;
  localparam int MAX_HIGH   = 48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        frame_done;
  logic        bit_error;
  logic [6:0]  pixel_count;
  logic        dout;

  always #12.5 clk = ~clk;

  ws2812_rx dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .bit_error   (bit_error),
    .pixel_count (pixel_count),
    .dout        (dout)
  );

`ifdef WS2812_FWD_EN
  logic [23:0] p2_data;
  logic        p2_valid, p2_frame, p2_err, p2_dout;
  logic [6:0]  p2_count;
  ws2812_rx dut2 (
    .clk (clk), .reset (reset), .din (dout), .pixel_data (p2_data), .pixel_valid (p2_valid),
    .frame_done (p2_frame), .bit_error (p2_err), .pixel_count (p2_count), .dout (p2_dout)
  );
`endif

  typedef struct {
    int          kind;   // 0 pixel, 1 frame_done, 2 bit_error alone
    logic [23:0] data;
    int          cnt;
    bit          err;
  } evt_t;

  evt_t        exp_q[$];
  logic [23:0] exp2_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model state: bits of the pixel being assembled, pixels in this frame, activity since last latch.
  logic [23:0] m_word;
  int          m_nbits, m_cnt, m_pif;
  bit          m_act;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic pop_evt(input int kind, output evt_t e, output bit ok);
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d, expected nothing at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      ok = (e.kind == kind);
    end
  endtask

  task automatic push(input int kind, input logic [23:0] data, input int cnt, input bit err);
    evt_t e;
    e.kind = kind; e.data = data; e.cnt = cnt; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_word = '0; m_nbits = 0; m_cnt = 0; m_pif = 0; m_act = 1'b0;
  endtask

  // One high pulse of h clocks followed by l clocks low.
  task automatic send_pulse(input int h, input int l);
    if (h > MAX_HIGH) begin
      push(2, '0, 0, 1'b1);
      m_nbits = 0;
    end else if (h < MIN_HIGH) begin
      push(2, '0, 0, 1'b1);
    end else begin
      m_word[m_nbits] = (h >= BIT_THRESH);
      m_nbits++;
      m_act = 1'b1;
      if (m_nbits == 24) begin
        m_nbits = 0;
        if (m_cnt < 127) m_cnt++;
        push(0, m_word, m_cnt, 1'b0);
        if (m_pif >= 1) exp2_q.push_back(m_word);
        m_pif++;
      end
    end
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input bit nominal);
    if (nominal)
      send_pulse(b ? T1H : T0H, b ? T1L : T0L);
    else
      send_pulse(b ? $urandom_range(BIT_THRESH, MAX_HIGH) : $urandom_range(MIN_HIGH, BIT_THRESH - 1),
                 $urandom_range(6, 60));
  endtask

  task automatic send_pixel(input logic [23:0] p, input bit nominal, input int glitch_at);
    for (int i = 0; i < 24; i++) begin
      if (i == glitch_at) send_pulse($urandom_range(1, MIN_HIGH - 1), 30);
      send_bit(p[i], nominal);
    end
  endtask

  task automatic latch(input int len);
    if (m_act) begin
      push(1, '0, 0, m_nbits != 0);
      m_act = 1'b0; m_nbits = 0; m_cnt = 0; m_pif = 0;
    end
    din = 1'b0;
    repeat (len) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel_data"}, pixel_data, 0);
    check({tag, "_pixel_valid"}, pixel_valid, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_bit_error"}, bit_error, 0);
    check({tag, "_pixel_count"}, pixel_count, 0);
    check({tag, "_dout"}, dout, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports something.
  bit fd_d = 1'b0;
  always @(negedge clk) begin : monitor
    evt_t e;
    bit   ok;
    if (reset) begin
      fd_d = 1'b0;
    end else begin
      if (fd_d) check("count_clear", pixel_count, 0);
      if (frame_done) begin
        pop_evt(1, e, ok);
        if (ok) check("frame_bit_error", bit_error, e.err);
      end
      if (pixel_valid) begin
        pop_evt(0, e, ok);
        if (ok) begin
          check("pixel_data", pixel_data, e.data);
          check("pixel_count", pixel_count, e.cnt);
        end
`ifndef WS2812_FWD_EN
        check("dout_tied_low", dout, 0);
`endif
      end
      if (bit_error && !frame_done) pop_evt(2, e, ok);
      fd_d = frame_done;
`ifdef WS2812_FWD_EN
      if (p2_valid) begin
        if (exp2_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL chained_unexpected: got %0h, expected nothing", p2_data);
        end else
          check("chained_pixel", p2_data, exp2_q.pop_front());
      end
`endif
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Single nominal pixel then latch.
    send_pixel(24'h00b000, 1'b1, -1);
    latch(T_RESET);
    // Three pixels in one frame.
    send_pixel(24'h00f060, 1'b1, -1);
    send_pixel(24'h00b0b0, 1'b1, -1);
    send_pixel(24'h0000b0, 1'b1, -1);
    latch(T_RESET);
    // Glitch mid-pixel is dropped; the pixel still assembles.
    send_pixel(24'h5a3c96, 1'b1, 10);
    latch(T_RESET);
    // Classification boundaries: 4/23 are zeros, 24/48 are ones, 3 is a glitch.
    send_pulse(4, 20); send_pulse(23, 20); send_pulse(24, 20); send_pulse(48, 20);
    send_pulse(3, 20);
    for (int i = 4; i < 24; i++) send_bit(i[0], 1'b1);
    latch(T_RESET);
    // Partial pixel at frame end.
    for (int i = 0; i < 10; i++) send_bit(i[1], 1'b1);
    latch(T_RESET);
    // Over-long high pulses (60 and just past the limit) abort the pixel.
    send_pulse(60, 40);
    send_pixel(24'hc3a501, 1'b1, -1);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1);
    send_pulse(MAX_HIGH + 1, 40);
    send_pixel(24'h123456, 1'b1, -1);
    latch(T_RESET);
    // Idle gap with no bits must stay silent.
    latch(T_RESET);

    // Randomised frames.
    for (int f = 0; f < 5; f++) begin
      int npix;
      npix = $urandom_range(1, 3);
      for (int p = 0; p < npix; p++)
        send_pixel(24'($urandom), 1'b0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 23) : -1);
      latch(T_RESET + $urandom_range(0, 200));
    end

    // Reset in the middle of a pixel.
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
    reset = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    model_reset();
    reset = 1'b0;
    latch(T_RESET);
    send_pixel(24'ha5f00f, 1'b1, -1);
    send_pixel(24'h0f0ff0, 1'b1, -1);
    latch(T_RESET);

    repeat (50) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef WS2812_FWD_EN
    check("chained_drained", exp2_q.size(), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
